byte_ram_clr: RTL
=================

// Module: byte_ram_clr
//
// PURPOSE
//  Successor single-clock RAM: port A read/write with per-byte write enables,
//  plus an independent read-only port B.
//  Adds a configurable read-during-write mode and an optional output register.
//  A hardware clear engine fills every word with INIT_VALUE after reset or on request.
//  Serves as the general-purpose data/frame memory behind CPU and video-side readers.
//
// PARAMETERS
//  DATA_WIDTH  16  word width in bits; must be a multiple of 8
//  ADDR_SPACE  16  address bits; depth = 1 << ADDR_SPACE
//  RDW_MODE    0   port A same-address read+write: 0 = old data, 1 = new (merged) data
//  OUT_REG     0   0 = read latency 1; 1 = extra output register, latency 2
//  INIT_VALUE  0   word written to every address by the clear engine
//
// PORTS
//  clock      in   1             single clock, rising edge
//  reset      in   1             asynchronous, active-high
//  clear      in   1             1-cycle pulse: start a full clear (honoured only when ready=1)
//  ready      out  1             1 = idle, accesses accepted; 0 = clearing
//  a_address  in   ADDR_SPACE    port A address
//  a_data     in   DATA_WIDTH    port A write data
//  a_byteen   in   DATA_WIDTH/8  byte-lane write enables, bit i -> data[8i+7:8i]
//  a_wren     in   1             port A write strobe
//  a_rden     in   1             port A read strobe
//  a_q        out  DATA_WIDTH    port A read data, held until the next read completes
//  a_valid    out  1             1-cycle pulse when a_q carries a completed read
//  b_address  in   ADDR_SPACE    port B address
//  b_rden     in   1             port B read strobe
//  b_q        out  DATA_WIDTH    port B read data, held
//  b_valid    out  1             1-cycle pulse when b_q carries a completed read
//
// BEHAVIOUR
//  - Reset (async): a_q = b_q = 0, a_valid = b_valid = 0, ready = 0.
//    FSM enters CLEAR with counter = 0; pipeline registers flush.
//    Memory contents are not reset directly; the clear engine rewrites them.
//  - FSM states and transitions:
//    - IDLE -> CLEAR on clear = 1.
//    - CLEAR writes INIT_VALUE at counter, then increments, one address per cycle.
//    - After writing address 2^ADDR_SPACE-1: -> IDLE, ready = 1 from the next cycle.
//    - ready = 0 for exactly 2^ADDR_SPACE cycles per clear.
//  - clear while in CLEAR: ignored; no restart.
//  - Reset mid-clear: async return to CLEAR at counter 0; a full clear runs again.
//  - Access gating: a_wren, a_rden and b_rden act only when ready = 1.
//    Otherwise they are dropped: no write and no valid pulse.
//  - Reads accepted before clear asserts still complete normally.
//  - Write: on accepted a_wren, only lanes with a_byteen bit = 1 are updated.
//    a_byteen = 0 writes nothing.
//  - Read latency: read accepted at edge N -> a_q/b_q updated and valid = 1 after
//    edge N+1 (OUT_REG = 0) or edge N+2 (OUT_REG = 1).
//  - Valid behaviour: back-to-back reads give back-to-back valid pulses.
//    Valid = 0 in any cycle with no completing read.
//  - Port A same-cycle read+write, same address:
//    - RDW_MODE 0: returns the pre-write word.
//    - RDW_MODE 1: returns the merged word (new lanes where a_byteen = 1, old lanes elsewhere).
//  - Port B reading the address port A writes in the same cycle: always returns the old word.
//  - Address wrap: addresses are exactly ADDR_SPACE bits; no out-of-range case exists.
//
// TESTING (DATA_WIDTH=16, ADDR_SPACE=4, INIT_VALUE=16'hA5A5)
//  1. Release reset -> ready = 0 for exactly 16 cycles, then 1.
//     Read addresses 0..15 on A and B -> every word is 16'hA5A5, one valid pulse each.
//  2. Write addr 3, a_data = 16'h1234, a_byteen = 2'b01 -> read addr 3 returns 16'hA534.
//  3. Same cycle: A writes 16'hBEEF to addr 5 and reads addr 5; B reads addr 5.
//     RDW_MODE 0 -> a_q = A5A5. RDW_MODE 1 -> a_q = BEEF. Both modes -> b_q = A5A5.
//  4. OUT_REG = 1: reads on 4 consecutive cycles -> 4 consecutive a_valid pulses,
//     the first 2 cycles after the first a_rden; data matches addresses.
//  5. Write several addresses, pulse clear -> ready = 0 for 16 cycles; writes issued
//     meanwhile are dropped; afterwards all addresses read 16'hA5A5.
//  6. Assert reset at clear cycle 7 -> outputs = 0 immediately; on release, ready
//     stays 0 for a full 16 cycles again.

Source files
------------

// File: rtl/byte_ram_clr.sv
// Single-clock RAM: byte-enabled read/write port A plus read-only port B,
// with a clear engine that fills every word with INIT_VALUE after reset or on request.
module byte_ram_clr #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_SPACE = 16,
    parameter int                    RDW_MODE   = 0,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    output logic                    ready,
    input  logic [ADDR_SPACE-1:0]   a_address,
    input  logic [DATA_WIDTH-1:0]   a_data,
    input  logic [DATA_WIDTH/8-1:0] a_byteen,
    input  logic                    a_wren,
    input  logic                    a_rden,
    output logic [DATA_WIDTH-1:0]   a_q,
    output logic                    a_valid,
    input  logic [ADDR_SPACE-1:0]   b_address,
    input  logic                    b_rden,
    output logic [DATA_WIDTH-1:0]   b_q,
    output logic                    b_valid
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_SPACE;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state, state_nx;
    logic [ADDR_SPACE-1:0] cnt;
    logic                  clr_we;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (clr_we) cnt <= cnt + 1'b1;
        end
    end

    // the counter wraps back to 0 on the last clear write, ready for the next clear
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (clear) state_nx = CLEAR;
            CLEAR:   if (cnt == '1) state_nx = IDLE;
            default: state_nx = CLEAR;
        endcase
    end

    always_comb begin
        ready  = (state == IDLE);
        clr_we = (state == CLEAR);
    end

    logic a_we, a_re, b_re;
    assign a_we = a_wren & ready;
    assign a_re = a_rden & ready;
    assign b_re = b_rden & ready;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wmask, a_old, b_old, a_merged, a_rd;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < NB; i++) wmask[8*i +: 8] = {8{a_byteen[i]}};
    end

    assign a_old    = mem[a_address];
    assign b_old    = mem[b_address];
    assign a_merged = (a_data & wmask) | (a_old & ~wmask);
    assign a_rd     = (RDW_MODE != 0 && a_we) ? a_merged : a_old;

    // clear writes and port A writes never coincide: port A is gated off while clearing
    always_ff @(posedge clock) begin
        if (clr_we)    mem[cnt]       <= INIT_VALUE;
        else if (a_we) mem[a_address] <= a_merged;
    end

    logic [DATA_WIDTH-1:0] a_d1, b_d1;
    logic                  a_v1, b_v1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_d1 <= '0;
            b_d1 <= '0;
            a_v1 <= 1'b0;
            b_v1 <= 1'b0;
        end else begin
            a_v1 <= a_re;
            b_v1 <= b_re;
            if (a_re) a_d1 <= a_rd;
            if (b_re) b_d1 <= b_old;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    a_q     <= '0;
                    b_q     <= '0;
                    a_valid <= 1'b0;
                    b_valid <= 1'b0;
                end else begin
                    a_valid <= a_v1;
                    b_valid <= b_v1;
                    if (a_v1) a_q <= a_d1;
                    if (b_v1) b_q <= b_d1;
                end
            end
        end else begin : g_direct
            assign a_q     = a_d1;
            assign b_q     = b_d1;
            assign a_valid = a_v1;
            assign b_valid = b_v1;
        end
    endgenerate
endmodule
